// File: rtl/sequence_player.sv
// ---------------------------------------------------------------------------
// sequence_player
//
// Plays a pseudo-random sequence of colored LED flashes. Each step lights one
// of four LEDs for ON_CYCLES clocks, then leaves all LEDs dark for
// OFF_CYCLES clocks. The color of each step comes from an 8-bit LFSR that is
// seeded at start, so the same seed always reproduces the same sequence.
//
// Parameters
//   ON_CYCLES   clocks each step's LED is lit        (1 .. 2^24-1)
//   OFF_CYCLES  clocks of dark gap after each step   (1 .. 2^24-1)
//
// Ports
//   clk        in   single clock, rising-edge
//   rst        in   synchronous active-high reset
//   start      in   request playback (sampled only in IDLE)
//   abort      in   cancel playback, return to IDLE without a done pulse
//   round_len  in   number of steps to play (latched at start)
//   seed       in   LFSR seed (latched at start; 0 is treated as 1)
//   led        out  one-hot lit color, 0 when dark
//   color      out  color index of the current step, valid while busy
//   step_idx   out  zero-based index of the current step
//   busy       out  high while a step is lit or in its gap
//   done       out  one-cycle pulse when playback completes normally
// ---------------------------------------------------------------------------
module sequence_player #(
    parameter int unsigned ON_CYCLES  = 8,
    parameter int unsigned OFF_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] round_len,
    input  logic [7:0] seed,
    output logic [3:0] led,
    output logic [1:0] color,
    output logic [3:0] step_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [23:0] ON_T  = 24'(ON_CYCLES);
    localparam logic [23:0] OFF_T = 24'(OFF_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP,
        DONE
    } state_t;

    state_t      state,    state_nxt;
    logic [23:0] timer,    timer_nxt;
    logic [7:0]  lfsr,     lfsr_nxt;
    logic [3:0]  len_q,    len_nxt;
    logic [3:0]  step_q,   step_nxt;
    logic [1:0]  color_q,  color_nxt;

    logic [7:0]  seed_eff;
    logic [7:0]  lfsr_adv;
    logic        last_step;

    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    assign seed_eff  = (seed == 8'h00) ? 8'h01 : seed;
    assign lfsr_adv  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign last_step = ({1'b0, step_q} + 5'd1) == {1'b0, len_q};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            lfsr    <= 8'h01;
            len_q   <= '0;
            step_q  <= '0;
            color_q <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            lfsr    <= lfsr_nxt;
            len_q   <= len_nxt;
            step_q  <= step_nxt;
            color_q <= color_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        lfsr_nxt  = lfsr;
        len_nxt   = len_q;
        step_nxt  = step_q;
        color_nxt = color_q;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        step_nxt = '0;
                        if (round_len == 4'd0) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = SHOW;
                            len_nxt   = round_len;
                            lfsr_nxt  = seed_eff;
                            color_nxt = seed_eff[1:0];
                            timer_nxt = ON_T;
                        end
                    end
                end

                SHOW: begin
                    // Timer counts down to 1, so a load of N gives N cycles.
                    if (timer <= 24'd1) begin
                        state_nxt = GAP;
                        timer_nxt = OFF_T;
                        lfsr_nxt  = lfsr_adv;
                    end else begin
                        timer_nxt = timer - 24'd1;
                    end
                end

                GAP: begin
                    if (timer <= 24'd1) begin
                        if (last_step) begin
                            state_nxt = DONE;
                            timer_nxt = '0;
                        end else begin
                            state_nxt = SHOW;
                            step_nxt  = step_q + 4'd1;
                            timer_nxt = ON_T;
                            // LFSR already advanced on the SHOW->GAP edge.
                            color_nxt = lfsr[1:0];
                        end
                    end else begin
                        timer_nxt = timer - 24'd1;
                    end
                end

                DONE: begin
                    state_nxt = IDLE;
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from the registered state
    // -----------------------------------------------------------------------
    always_comb begin
        led      = '0;
        busy     = 1'b0;
        done     = 1'b0;
        color    = color_q;
        step_idx = step_q;

        unique case (state)
            SHOW: begin
                led  = 4'(4'b0001 << lfsr[1:0]);
                busy = 1'b1;
            end
            GAP: begin
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                led = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_player.sv
// ---------------------------------------------------------------------------
// tb_sequence_player
//
// Randomized scoreboard bench for sequence_player. The driver pushes the
// expected list of step colors and the expected busy length for every
// accepted start; an independent monitor watches the LED outputs on the
// falling clock edge and checks each lit step, its lit and dark durations and
// the done pulse against those expectations.
// ---------------------------------------------------------------------------
module tb_sequence_player;

    localparam int ON  = 8;
    localparam int OFF = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] round_len;
    logic [7:0] seed;
    logic [3:0] led;
    logic [1:0] color;
    logic [3:0] step_idx;
    logic       busy;
    logic       done;

    sequence_player #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .round_len(round_len),
        .seed     (seed),
        .led      (led),
        .color    (color),
        .step_idx (step_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int color;
        int idx;
    } step_t;

    step_t step_q[$];
    int    done_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference LFSR: shift left, new bit is the parity of taps 7,5,4,3.
    function automatic logic [7:0] next_lfsr(input logic [7:0] v);
        logic [7:0] taps;
        taps = v & 8'hB8;
        return 8'((int'(v) * 2) % 256) | 8'(^taps);
    endfunction

    task automatic expect_run(input logic [7:0] s, input logic [3:0] n);
        logic [7:0] v;
        step_t      st;
        if (n == 4'd0) begin
            done_q.push_back(0);
        end else begin
            v = (s == 8'h00) ? 8'h01 : s;
            for (int i = 0; i < int'(n); i++) begin
                st.color = int'(v % 4);
                st.idx   = i;
                step_q.push_back(st);
                v = next_lfsr(v);
            end
            done_q.push_back(int'(n) * (ON + OFF));
        end
    endtask

    task automatic flush();
        step_q.delete();
        done_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((step_q.size() != 0 || done_q.size() != 0 || busy || done) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL run_timeout actual=%0d cycles expected<%0d", n, budget);
            flush();
        end
    endtask

    // mode 0: plain run; 1: re-pulse start and change round_len after k
    // cycles; 2: abort after k cycles.
    task automatic play(input logic [7:0] s, input logic [3:0] n, input int mode, input int k);
        round_len = n;
        seed      = s;
        start     = 1'b1;
        expect_run(s, n);
        @(posedge clk);
        #1;
        start     = 1'b0;
        seed      = 8'($urandom);
        round_len = 4'($urandom);
        if (n == 4'd0) chk("zero_len_done", int'(done), 1);
        if (mode == 1) begin
            repeat (k) @(posedge clk);
            #1;
            start     = 1'b1;
            round_len = 4'd9;
            @(posedge clk);
            #1;
            start = 1'b0;
        end else if (mode == 2) begin
            repeat (k) @(posedge clk);
            #1;
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            chk("abort_busy", int'(busy), 0);
            chk("abort_led", int'(led), 0);
            flush();
        end
        wait_idle(int'(n) * (ON + OFF) + 20);
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    logic [3:0] pled  = '0;
    logic       pbusy = 1'b0;
    logic [3:0] exp_led = '0;
    int         lit = 0, gap = 0, run = 0, prun = 0;
    bit         first = 1'b1;

    always @(negedge clk) begin
        step_t st;
        int    e;
        if (busy && !pbusy) begin
            first = 1'b1;
            lit   = 0;
            gap   = 0;
            run   = 0;
        end
        if (busy) begin
            run++;
        end else begin
            prun = run;
            run  = 0;
        end

        if (busy && led != 4'd0) begin
            if (pled == 4'd0) begin
                checks++;
                if (step_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_step actual led=%b expected no step", led);
                end else begin
                    st = step_q.pop_front();
                    exp_led = 4'(1 << st.color);
                    chk("step_color", int'(color), st.color);
                    chk("step_idx", int'(step_idx), st.idx);
                    if (!first) chk("gap_len", gap, OFF);
                end
                first = 1'b0;
                lit   = 0;
            end
            chk("led_lit", int'(led), int'(exp_led));
            lit++;
        end else if (busy) begin
            if (pled != 4'd0) begin
                chk("lit_len", lit, ON);
                gap = 0;
            end
            gap++;
        end else begin
            chk("led_idle", int'(led), 0);
        end

        if (done) begin
            chk("done_busy", int'(busy), 0);
            checks++;
            if (done_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done actual done=1 expected done=0");
            end else begin
                e = done_q.pop_front();
                chk("busy_len", prun, e);
                if (e > 0) chk("last_gap", gap, OFF);
            end
        end

        pled  = led;
        pbusy = busy;
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int mode, k, n;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        round_len = '0;
        seed      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_step", int'(step_idx), 0);
        chk("rst_color", int'(color), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reference run, then step_idx must hold its last value in IDLE.
        play(8'hA5, 4'd3, 0, 0);
        chk("idle_step_hold", int'(step_idx), 2);

        // Zero length and zero seed.
        play(8'h3C, 4'd0, 0, 0);
        play(8'h00, 4'd1, 0, 0);

        // Start re-pulsed mid-SHOW with round_len changed to 9.
        play(8'hA5, 4'd3, 1, 3);

        // Abort during the first gap, then a clean replay.
        play(8'hA5, 4'd3, 2, 9);
        repeat (5) @(posedge clk);
        #1;
        play(8'hA5, 4'd3, 0, 0);

        // Abort and start together in IDLE: abort wins.
        round_len = 4'd3;
        start     = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", int'(busy), 0);
        chk("abort_start_done", int'(done), 0);
        @(posedge clk);
        #1;
        chk("abort_start_idle", int'(busy), 0);

        // Reset during GAP, then the reference run must repeat exactly.
        round_len = 4'd3;
        seed      = 8'hA5;
        start     = 1'b1;
        expect_run(8'hA5, 4'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush();
        chk("midrst_led", int'(led), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_step", int'(step_idx), 0);
        chk("midrst_color", int'(color), 0);
        repeat (3) @(posedge clk);
        #1;
        play(8'hA5, 4'd3, 0, 0);

        // Randomized runs.
        for (int it = 0; it < 30; it++) begin
            n    = $urandom_range(0, 15);
            mode = (n == 0) ? 0 : $urandom_range(0, 2);
            k    = (n == 0) ? 0 : $urandom_range(1, n * (ON + OFF) - 1);
            play(8'($urandom), 4'(n), mode, k);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (step_q.size() != 0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations actual steps=%0d dones=%0d expected 0",
                     step_q.size(), done_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 The block SHALL have parameter ON_CYCLES, default 8, clock cycles each step's LED is lit (legal range 1..2^24-1).
REQ-002 The block SHALL have parameter OFF_CYCLES, default 4, clock cycles of dark gap after each step (legal range 1..2^24-1).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  request playback; sampled only in IDLE.
REQ-006 The block SHALL have port abort  input  1  cancel playback; return to IDLE.
REQ-007 The block SHALL have port round_len  input  4  number of steps to play; this is the stored round count from the sequence memory.
REQ-008 The block SHALL have port seed  input  8  LFSR seed; the same seed SHALL reproduce the same color sequence.
REQ-009 The block SHALL have port led  output  4  one-hot lit color; 4'b0000 when dark.
REQ-010 The block SHALL have port color  output  2  color index of the current step, valid while busy.
REQ-011 The block SHALL have port step_idx  output  4  zero-based index of the current step.
REQ-012 The block SHALL have port busy  output  1  high while playback is in progress.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse when playback completes.

Function
REQ-014 The FSM SHALL have states IDLE, SHOW, GAP and DONE.
REQ-015 IDLE, start=1 and round_len!=0: on the next cycle the FSM SHALL be in SHOW; at the same edge it SHALL latch round_len, load lfsr<=seed (8'h01 if seed==0), set step_idx=0 and set timer=ON_CYCLES.
REQ-016 IDLE, start=1 and round_len==0: the FSM SHALL go to DONE; no LED SHALL light.
REQ-017 SHOW: led SHALL equal 1<<lfsr[1:0] and color SHALL equal lfsr[1:0], for exactly ON_CYCLES cycles; the FSM SHALL then go to GAP with timer=OFF_CYCLES.
REQ-018 On the SHOW->GAP edge, the LFSR SHALL advance once: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-019 GAP: led SHALL be 0 for exactly OFF_CYCLES cycles.
REQ-020 At the end of GAP, if step_idx+1 == latched length the FSM SHALL go to DONE; otherwise step_idx SHALL increment and the FSM SHALL go to SHOW with timer=ON_CYCLES.
REQ-021 DONE SHALL last exactly one cycle with done=1, busy=0, led=0, then go to IDLE.
REQ-022 busy SHALL be 1 in SHOW and GAP, and 0 in IDLE and DONE.
REQ-023 For N>0 steps, busy SHALL be high for exactly N*(ON_CYCLES+OFF_CYCLES) cycles, and done SHALL assert on the cycle immediately after busy falls.
REQ-024 start SHALL be ignored in SHOW, GAP and DONE.
REQ-025 Changes to round_len or seed during playback SHALL have no effect until the next accepted start.
REQ-026 abort=1 in any state SHALL force IDLE on the next edge with led=0 and busy=0, and SHALL NOT produce a done pulse.
REQ-027 If abort and start are both 1 in IDLE, abort SHALL win and the FSM SHALL remain in IDLE.
REQ-028 The timer SHALL be 24 bits wide and SHALL count down to 1, so there is no off-by-one in the on/off durations.
REQ-029 step_idx SHALL hold its last value in IDLE and SHALL reset to 0 only on rst or an accepted start.

Reset
REQ-030 rst=1 SHALL, at the next edge, set state=IDLE, led=0, color=0, step_idx=0, busy=0, done=0, timer=0 and lfsr=8'h01.
REQ-031 rst SHALL take priority over start and abort, including mid-playback, and SHALL NOT produce a done pulse.

Verification
REQ-032 Test: seed=8'hA5, round_len=3, ON=8, OFF=4, start pulsed -> led sequence 0010, 0100, 0010, each lit 8 cycles with 4 dark cycles after; busy high 36 cycles; done pulses once at cycle 37 after start.
REQ-033 Test: round_len=0 with start -> done pulses the next cycle; busy and led stay 0.
REQ-034 Test: seed=8'h00, round_len=1 -> behaves as seed 8'h01; led=0010 for 8 cycles.
REQ-035 Test: start re-pulsed mid-SHOW, and round_len changed 3->9 mid-playback -> ignored; exactly 3 steps play.
REQ-036 Test: abort at cycle 10 of the REQ-032 run -> led=0 and busy=0 next cycle, no done pulse; a new start then replays from 0010.
REQ-037 Test: rst asserted during GAP -> all outputs reach their reset values next cycle, no done pulse; a repeat of the REQ-032 run gives the identical sequence.
